// File: rtl/cpu_fsm.sv
// Moore controller for a simple 16-bit datapath: MOV imm, MOV reg (with shift), ADD/CMP/AND/MVN.
// Start handshake: an instruction is accepted on a rising edge where w=1 and s=1. Optional HALT trap: SRM_ILLEGAL_TRAP_EN.
module cpu_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic        err,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic [2:0]  writenum,
    output logic [2:0]  readnum,
    output logic [1:0]  shift,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        WAIT      = 3'd0,
        DECODE    = 3'd1,
        WRITE_IMM = 3'd2,
        GET_A     = 3'd3,
        GET_B     = 3'd4,
        ALU       = 3'd5,
        WRITE_REG = 3'd6
`ifdef SRM_ILLEGAL_TRAP_EN
        ,HALT     = 3'd7
`endif
    } state_t;

    state_t      state, next;
    logic [15:0] ir;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_mov_imm, is_mov_reg, is_alu;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);

    assign sximm8    = {{8{ir[7]}}, ir[7:0]};
    assign sximm5    = {{11{ir[4]}}, ir[4:0]};
    assign w         = (state == WAIT);
    assign dbg_state = state;

`ifdef SRM_ILLEGAL_TRAP_EN
    // HALT is only left through reset, so the state itself is the sticky flag.
    assign err = (state == HALT);
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT;
            ir    <= 16'h0000;
        end else begin
            state <= next;
            if (state == WAIT && s)
                ir <= in;
        end
    end

    always_comb begin
        next     = state;
        vsel     = 2'b00;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        write    = 1'b0;
        writenum = 3'b000;
        readnum  = 3'b000;
        shift    = 2'b00;
        asel     = 1'b0;
        bsel     = 1'b0;
        ALUop    = 2'b00;
        case (state)
            WAIT: begin
                if (s)
                    next = DECODE;
            end
            DECODE: begin
                if (is_mov_imm)
                    next = WRITE_IMM;
                else if (is_mov_reg)
                    next = GET_B;
                else if (is_alu)
                    next = GET_A;
                else
`ifdef SRM_ILLEGAL_TRAP_EN
                    next = HALT;
`else
                    next = WAIT;
`endif
            end
            WRITE_IMM: begin
                vsel     = 2'b01;
                writenum = rn;
                write    = 1'b1;
                next     = WAIT;
            end
            GET_A: begin
                readnum = rn;
                loada   = 1'b1;
                next    = GET_B;
            end
            GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
                next    = ALU;
            end
            ALU: begin
                shift = sh;
                loadc = 1'b1;
                if (is_mov_reg) begin
                    asel = 1'b1;
                    next = WRITE_REG;
                end else begin
                    ALUop = op;
                    // CMP only updates status; there is no result to write back.
                    loads = (op == 2'b01);
                    next  = (op == 2'b01) ? WAIT : WRITE_REG;
                end
            end
            WRITE_REG: begin
                vsel     = 2'b10;
                writenum = rd;
                write    = 1'b1;
                next     = WAIT;
            end
`ifdef SRM_ILLEGAL_TRAP_EN
            HALT: next = HALT;
`endif
            default: next = WAIT;
        endcase
    end

endmodule
